v_state_rd_arb: RTL and testbench

// - Round-robin arbiter sharing the single state-table read port (ren/raddr/rdata) among N_REQ pipes (query pipe, update pipe, ...).
// - Each requester sees a private request/grant/response channel. Responses return in order with fixed latency, steered by a one-hot tag.
// - Sits between the v_pipe_* blocks and the state RAM. Its outputs drive o_state_ren/o_state_raddr directly.
//

---
 rtl/v_state_rd_arb_if.sv | 14 +
 rtl/v_state_rd_arb.sv | 78 +++++++
 tb/tb_v_state_rd_arb.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/v_state_rd_arb_if.sv
// v_state_rd_arb_if: per-requester read request/grant/response channel of the state-RAM read arbiter.
interface v_state_rd_arb_if #(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64
);
    logic [N_REQ-1:0]        req_vld;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ-1:0]        req_gnt;
    logic [N_REQ-1:0]        rsp_vld;
    logic [DATA_W-1:0]       rsp_rdata;
    modport master (output req_vld, req_addr, input req_gnt, rsp_vld, rsp_rdata);
    modport slave  (input req_vld, req_addr, output req_gnt, rsp_vld, rsp_rdata);
endinterface

// File: rtl/v_state_rd_arb.sv
// v_state_rd_arb: round-robin arbiter sharing one state-RAM read port among N_REQ pipes.
// Define V_STATE_RD_ARB_RSP_FLOP_EN to register the response (grant-to-response latency 3 instead of 2).
module v_state_rd_arb #(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    v_state_rd_arb_if.slave   bus,
    input  logic              i_stall,
    output logic              o_state_ren,
    output logic [ADDR_W-1:0] o_state_raddr,
    input  logic [DATA_W-1:0] i_state_rdata,
    output logic              o_busy
);
    localparam int PW = $clog2(N_REQ);

    logic [PW-1:0]     r_ptr, w_win;
    logic              w_any;
    logic [N_REQ-1:0]  w_gnt, r_s1_tag, r_s2_tag;
    logic [ADDR_W-1:0] w_addr, r_raddr;

    always_comb begin
        w_any  = |bus.req_vld;
        w_win  = r_ptr;
        w_addr = '0;
        for (int i = N_REQ - 1; i >= 0; i--)
            if (bus.req_vld[i]) w_win = PW'(i);
        // the lowest requester above the pointer beats the wrapped-around lowest one
        for (int i = N_REQ - 1; i >= 0; i--)
            if (bus.req_vld[i] && i > int'(r_ptr)) w_win = PW'(i);
        for (int i = 0; i < N_REQ; i++)
            if (w_win == PW'(i)) w_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
        w_gnt = (w_any && !i_stall) ? N_REQ'(1) << w_win : '0;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_ptr    <= PW'(N_REQ - 1);
            r_raddr  <= '0;
            r_s1_tag <= '0;
            r_s2_tag <= '0;
        end else begin
            if (|w_gnt) begin
                r_ptr   <= w_win;
                r_raddr <= w_addr;
            end
            r_s1_tag <= w_gnt;
            r_s2_tag <= r_s1_tag;
        end

    assign bus.req_gnt   = w_gnt;
    assign o_state_ren   = |r_s1_tag;
    assign o_state_raddr = r_raddr;

`ifdef V_STATE_RD_ARB_RSP_FLOP_EN
    logic [N_REQ-1:0]  r_s3_tag;
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_s3_tag <= '0;
            r_rdata  <= '0;
        end else begin
            r_s3_tag <= r_s2_tag;
            if (|r_s2_tag) r_rdata <= i_state_rdata;
        end

    assign bus.rsp_vld   = r_s3_tag;
    assign bus.rsp_rdata = r_rdata;
    assign o_busy        = |{r_s1_tag, r_s2_tag, r_s3_tag};
`else
    assign bus.rsp_vld   = r_s2_tag;
    assign bus.rsp_rdata = |r_s2_tag ? i_state_rdata : '0;
    assign o_busy        = |{r_s1_tag, r_s2_tag};
`endif
endmodule

// File: tb/tb_v_state_rd_arb.sv
// tb_v_state_rd_arb: directed bench with a fixed-latency scoreboard for v_state_rd_arb.
module tb_v_state_rd_arb;
    localparam int N = 2;
`ifdef V_STATE_RD_ARB_RSP_FLOP_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    typedef struct {
        logic [N-1:0] tag;
        logic [7:0]   addr;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        ren;
    logic [7:0]  raddr;
    logic [63:0] rdata = '0;
    logic        busy;
    int          n_assert = 0;
    int          n_fail = 0;
    int          tb_ptr;
    ent_t        sb[$];

    v_state_rd_arb_if #(.N_REQ(N), .ADDR_W(8), .DATA_W(64)) bus ();

    v_state_rd_arb #(.N_REQ(N), .ADDR_W(8), .DATA_W(64)) dut (
        .clk(clk), .rst(rst), .bus(bus), .i_stall(stall),
        .o_state_ren(ren), .o_state_raddr(raddr), .i_state_rdata(rdata), .o_busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ram_val(input logic [7:0] a);
        return {4{a, a ^ 8'h5A}};
    endfunction

    always @(posedge clk) if (ren) rdata <= ram_val(raddr);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic sb_reset();
        ent_t z;
        z.tag  = '0;
        z.addr = '0;
        sb.delete();
        repeat (LAT) sb.push_back(z);
        tb_ptr = N - 1;
    endtask

    task automatic drive(input logic [N-1:0] v, input logic [7:0] a0, input logic [7:0] a1);
        bus.req_vld  = v;
        bus.req_addr = {a1, a0};
    endtask

    task automatic step();
        logic [N-1:0] eg;
        logic         eb;
        int           w;
        ent_t         c, e;
        #1;
        eg = '0;
        w  = -1;
        if (!stall)
            for (int k = 1; k <= N; k++)
                if (w < 0 && bus.req_vld[(tb_ptr + k) % N]) w = (tb_ptr + k) % N;
        if (w >= 0) eg[w] = 1'b1;
        chk("gnt", 64'(bus.req_gnt), 64'(eg));
        c = sb.pop_front();
        chk("rsp_vld", 64'(bus.rsp_vld), 64'(c.tag));
        if (c.tag != 0) chk("rsp_rdata", bus.rsp_rdata, ram_val(c.addr));
        chk("ren", 64'(ren), 64'(sb[$].tag != 0));
        if (sb[$].tag != 0) chk("raddr", 64'(raddr), 64'(sb[$].addr));
        eb = c.tag != 0;
        foreach (sb[i]) eb |= sb[i].tag != 0;
        chk("busy", 64'(busy), 64'(eb));
        e.tag  = eg;
        e.addr = (w >= 0) ? bus.req_addr[w*8 +: 8] : 8'h00;
        sb.push_back(e);
        if (w >= 0) tb_ptr = w;
        @(negedge clk);
    endtask

    initial begin
        rst   = 1'b1;
        stall = 1'b0;
        drive(2'b00, 8'h00, 8'h00);
        sb_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_gnt", 64'(bus.req_gnt), 64'd0);
        chk("rst_ren", 64'(ren), 64'd0);
        chk("rst_raddr", 64'(raddr), 64'd0);
        chk("rst_rsp_vld", 64'(bus.rsp_vld), 64'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        // single request
        drive(2'b01, 8'h12, 8'h00);
        step();
        drive(2'b00, 8'h00, 8'h00);
        repeat (3) step();
        // contention, both held
        drive(2'b11, 8'h20, 8'h21);
        repeat (6) step();
        // stall with reads in flight, then resume
        stall = 1'b1;
        repeat (3) step();
        stall = 1'b0;
        repeat (3) step();
        // back-to-back from r1 alone
        for (int i = 0; i < 16; i++) begin
            drive(2'b10, 8'h00, 8'(i));
            step();
        end
        // r1 requests for one cycle while r0 wins, then drops
        drive(2'b11, 8'h30, 8'h31);
        step();
        drive(2'b00, 8'h00, 8'h00);
        repeat (3) step();
        // r0 drops as r1 rises
        drive(2'b01, 8'h40, 8'h00);
        step();
        drive(2'b10, 8'h00, 8'h41);
        step();
        // same address on both
        drive(2'b11, 8'h55, 8'h55);
        repeat (2) step();
        drive(2'b00, 8'h00, 8'h00);
        repeat (3) step();
        // reset one cycle after a grant
        drive(2'b01, 8'h77, 8'h00);
        step();
        drive(2'b00, 8'h00, 8'h00);
        rst = 1'b1;
        #1;
        chk("mid_rst_ren", 64'(ren), 64'd0);
        chk("mid_rst_rsp_vld", 64'(bus.rsp_vld), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        sb_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) step();
        drive(2'b11, 8'h60, 8'h61);
        repeat (2) step();
        drive(2'b00, 8'h00, 8'h00);
        repeat (4) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
